// File: rtl/execute_pipe.sv
// execute_pipe: registered execute stage with operand select, ALU and a valid/ready output register.
// Define EXECUTE_MULDIV_EN to add the iterative M-extension mul/div unit (op codes 16-23).
module execute_pipe #(
  parameter int XLEN  = 32,
  parameter int OP_W  = 5,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [1:0]       src_a_sel,
  input  logic [1:0]       src_b_sel,
  input  logic [OP_W-1:0]  alu_op_sel,
  input  logic [REG_W-1:0] rd_addr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_out,
  output logic [REG_W-1:0] out_rd_addr,
  output logic             illegal
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [OP_W-1:0] OP_ADD    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLL    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLT    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLTU   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA    = OP_W'(7);
  localparam logic [OP_W-1:0] OP_OR     = OP_W'(8);
  localparam logic [OP_W-1:0] OP_AND    = OP_W'(9);
  localparam logic [OP_W-1:0] OP_PASS_B = OP_W'(10);

  logic [XLEN-1:0]  op_a, op_b;
  logic [SHW-1:0]   shamt;
  logic [XLEN-1:0]  alu_res;
  logic             alu_legal;
  logic             idle;
  logic             accept;
  logic             start_m;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  alu_out_q, alu_out_d;
  logic [REG_W-1:0] out_rd_q, out_rd_d;
  logic             illegal_q, illegal_d;

  always_comb begin
    case (src_a_sel)
      2'd0:    op_a = rs1_data;
      2'd1:    op_a = pc;
      default: op_a = '0;
    endcase
    case (src_b_sel)
      2'd0:    op_b = rs2_data;
      2'd1:    op_b = imm;
      2'd2:    op_b = XLEN'(4);
      default: op_b = '0;
    endcase
  end

  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (alu_op_sel)
      OP_ADD:    alu_res = op_a + op_b;
      OP_SUB:    alu_res = op_a - op_b;
      OP_SLL:    alu_res = op_a << shamt;
      OP_SLT:    alu_res = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU:   alu_res = XLEN'(op_a < op_b);
      OP_XOR:    alu_res = op_a ^ op_b;
      OP_SRL:    alu_res = op_a >> shamt;
      OP_SRA:    alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_OR:     alu_res = op_a | op_b;
      OP_AND:    alu_res = op_a & op_b;
      OP_PASS_B: alu_res = op_b;
      default:   alu_legal = 1'b0;
    endcase
  end

  assign in_ready = idle && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

`ifdef EXECUTE_MULDIV_EN
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_REMU = OP_W'(23);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_d;
  logic [SHW-1:0]      count_q, count_d;
  logic [2:0]          m_op_q, m_op_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic [REG_W-1:0]    rd_q, rd_d;
  logic [2*XLEN-1:0]   prod_q, prod_d, prod_step, prod_fix;
  logic [XLEN-1:0]     mcand, divisor, m_result, quot, rem;
  logic [XLEN:0]       mul_sum, rem_shift, rem_diff;
  logic                a_neg, b_neg, m_done;

  // op[2] selects the divider; op[1:0] picks the variant within mul or div
  function automatic logic sign_a_of(input logic [2:0] op);
    return op[2] ? !op[0] : (op[1] ^ op[0]);
  endfunction

  function automatic logic sign_b_of(input logic [2:0] op);
    return op[2] ? !op[0] : (op[1:0] == 2'b01);
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
    return (s && v[XLEN-1]) ? -v : v;
  endfunction

  assign idle    = (state_q == IDLE);
  assign start_m = accept && (alu_op_sel >= OP_MUL) && (alu_op_sel <= OP_REMU);

  // prod holds {hi, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    mcand     = mag(a_q, sign_a_of(m_op_q));
    divisor   = mag(b_q, sign_b_of(m_op_q));
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand} : '0);
    rem_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    if (!m_op_q[2])
      prod_step = {mul_sum, prod_q[XLEN-1:1]};
    else if (rem_diff[XLEN])
      prod_step = {rem_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
    else
      prod_step = {rem_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    a_neg    = sign_a_of(m_op_q) && a_q[XLEN-1];
    b_neg    = sign_b_of(m_op_q) && b_q[XLEN-1];
    prod_fix = (a_neg ^ b_neg) ? -prod_step : prod_step;
    quot     = prod_step[XLEN-1:0];
    rem      = prod_step[2*XLEN-1:XLEN];
    if (!m_op_q[2])
      m_result = (m_op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (b_q == '0)
      m_result = m_op_q[1] ? a_q : '1;
    else if (m_op_q[1])
      m_result = a_neg ? -rem : rem;
    else
      m_result = (a_neg ^ b_neg) ? -quot : quot;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    m_op_d  = m_op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    prod_d  = prod_q;
    m_done  = 1'b0;
    if (state_q == IDLE) begin
      if (start_m) begin
        state_d = BUSY;
        count_d = '0;
        m_op_d  = alu_op_sel[2:0];
        a_d     = op_a;
        b_d     = op_b;
        rd_d    = rd_addr;
        prod_d  = alu_op_sel[2] ? {XLEN'(0), mag(op_a, sign_a_of(alu_op_sel[2:0]))}
                                : {XLEN'(0), mag(op_b, sign_b_of(alu_op_sel[2:0]))};
      end
    end else if (flush) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      prod_d  = prod_step;
      count_d = count_q + 1'b1;
      if (count_q == SHW'(XLEN-1)) begin
        state_d = IDLE;
        count_d = '0;
        m_done  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      m_op_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      m_op_q  <= m_op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      prod_q  <= prod_d;
    end
  end
`else
  assign idle    = 1'b1;
  assign start_m = 1'b0;
`endif

  // flush is applied last so it overrides both completion and consumption
  always_comb begin
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    out_rd_d    = out_rd_q;
    illegal_d   = illegal_q;
    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;
    if (accept && !start_m) begin
      out_valid_d = 1'b1;
      alu_out_d   = alu_legal ? alu_res : '0;
      illegal_d   = !alu_legal;
      out_rd_d    = rd_addr;
    end
`ifdef EXECUTE_MULDIV_EN
    if (m_done) begin
      out_valid_d = 1'b1;
      alu_out_d   = m_result;
      illegal_d   = 1'b0;
      out_rd_d    = rd_q;
    end
`endif
    if (flush)
      out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      out_rd_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      out_rd_q    <= out_rd_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_out     = alu_out_q;
  assign out_rd_addr = out_rd_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Directed self-checking bench for execute_pipe: vector table for single-cycle ops,
// hand sequences for backpressure, flush, reset and (with EXECUTE_MULDIV_EN) mul/div.
`timescale 1ns/1ps
module tb_execute_pipe;

  localparam int XLEN  = 32;
  localparam int OP_W  = 5;
  localparam int REG_W = 5;
  localparam int NV    = 16;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  SLL = 5'd2,  SLT = 5'd3;
  localparam logic [4:0] SLTU = 5'd4, XOR = 5'd5,  SRL = 5'd6,  SRA = 5'd7;
  localparam logic [4:0] OR = 5'd8,   AND = 5'd9,  PASSB = 5'd10;
  localparam logic [4:0] MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18, MULHU = 5'd19;
  localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21, REM = 5'd22,   REMU = 5'd23;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  pc, imm, rs1_data, rs2_data;
  logic [1:0]       src_a_sel, src_b_sel;
  logic [OP_W-1:0]  alu_op_sel;
  logic [REG_W-1:0] rd_addr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  alu_out;
  logic [REG_W-1:0] out_rd_addr;
  logic             illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [4:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pcv;
    logic [31:0] immv;
    logic [4:0]  rd;
    logic [31:0] exp_out;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[NV];

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  execute_pipe #(.XLEN(XLEN), .OP_W(OP_W), .REG_W(REG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pc          (pc),
    .imm         (imm),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .src_a_sel   (src_a_sel),
    .src_b_sel   (src_b_sel),
    .alu_op_sel  (alu_op_sel),
    .rd_addr     (rd_addr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_out     (alu_out),
    .out_rd_addr (out_rd_addr),
    .illegal     (illegal)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] a_sel, input logic [1:0] b_sel, input logic [4:0] op,
                               input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pcv,
                               input logic [31:0] immv, input logic [4:0] rd);
    src_a_sel  = a_sel;
    src_b_sel  = b_sel;
    alu_op_sel = op;
    rs1_data   = rs1;
    rs2_data   = rs2;
    pc         = pcv;
    imm        = immv;
    rd_addr    = rd;
    in_valid   = 1'b1;
  endtask

  // Issue one op from a negedge and check the result one edge later
  task automatic singleOp(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic exp_ill);
    @(negedge clk);
    applyStimulus(2'd0, 2'd0, op, a, b, 32'h0, 32'h0, 5'd17);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput({name, "_valid"}, out_valid, 1);
    checkOutput({name, "_out"}, alu_out, exp);
    checkOutput({name, "_illegal"}, illegal, exp_ill);
    checkOutput({name, "_rd"}, out_rd_addr, 17);
  endtask

`ifdef EXECUTE_MULDIV_EN
  task automatic runM(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
    int  n;
    bit  seen;
    @(negedge clk);
    applyStimulus(2'd0, 2'd0, op, a, b, 32'h0, 32'h0, 5'd9);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput({name, "_busy_valid"}, out_valid, 0);
    checkOutput({name, "_busy_ready"}, in_ready, 0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) seen = 1'b1;
    end
    checkOutput({name, "_done"}, seen, 1);
    checkOutput({name, "_latency"}, n, XLEN);
    checkOutput({name, "_out"}, alu_out, exp);
    checkOutput({name, "_illegal"}, illegal, 0);
    checkOutput({name, "_rd"}, out_rd_addr, 9);
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int vcount;

    vecs[0]  = '{2'd0, 2'd0, ADD,    32'd5,         32'd7,         32'h0,   32'h0,         5'd1,  32'd12,        1'b0};
    vecs[1]  = '{2'd1, 2'd2, ADD,    32'h0,         32'h0,         32'h100, 32'h0,         5'd2,  32'h104,       1'b0};
    vecs[2]  = '{2'd0, 2'd1, SRA,    32'h80000000,  32'h0,         32'h0,   32'd4,         5'd3,  32'hF8000000,  1'b0};
    vecs[3]  = '{2'd0, 2'd0, SUB,    32'd3,         32'd5,         32'h0,   32'h0,         5'd4,  32'hFFFFFFFE,  1'b0};
    vecs[4]  = '{2'd0, 2'd0, SLT,    32'hFFFFFFFF,  32'd1,         32'h0,   32'h0,         5'd5,  32'd1,         1'b0};
    vecs[5]  = '{2'd0, 2'd0, SLTU,   32'hFFFFFFFF,  32'd1,         32'h0,   32'h0,         5'd6,  32'd0,         1'b0};
    vecs[6]  = '{2'd0, 2'd0, SLL,    32'd1,         32'h21,        32'h0,   32'h0,         5'd7,  32'd2,         1'b0};
    vecs[7]  = '{2'd0, 2'd0, SRL,    32'h80000000,  32'd31,        32'h0,   32'h0,         5'd8,  32'd1,         1'b0};
    vecs[8]  = '{2'd0, 2'd0, XOR,    32'hF0F0F0F0,  32'hFF00FF00,  32'h0,   32'h0,         5'd9,  32'h0FF00FF0,  1'b0};
    vecs[9]  = '{2'd0, 2'd0, OR,     32'h0F0,       32'h00F,       32'h0,   32'h0,         5'd10, 32'hFF,        1'b0};
    vecs[10] = '{2'd0, 2'd0, AND,    32'hF0F0F0F0,  32'hFF00FF00,  32'h0,   32'h0,         5'd11, 32'hF000F000,  1'b0};
    vecs[11] = '{2'd0, 2'd1, PASSB,  32'h1,         32'h2,         32'h0,   32'hDEADBEEF,  5'd12, 32'hDEADBEEF,  1'b0};
    vecs[12] = '{2'd2, 2'd0, ADD,    32'h1234,      32'h55,        32'h0,   32'h0,         5'd13, 32'h55,        1'b0};
    vecs[13] = '{2'd3, 2'd3, ADD,    32'd9,         32'd9,         32'h77,  32'h66,        5'd14, 32'h0,         1'b0};
    vecs[14] = '{2'd0, 2'd0, 5'd25,  32'd1,         32'd2,         32'h0,   32'h0,         5'd15, 32'h0,         1'b1};
    vecs[15] = '{2'd0, 2'd0, 5'd11,  32'd3,         32'd4,         32'h0,   32'h0,         5'd16, 32'h0,         1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    applyStimulus(2'd0, 2'd0, ADD, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    in_valid  = 1'b0;
    #12;
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_out", alu_out, 0);
    checkOutput("reset_rd", out_rd_addr, 0);
    checkOutput("reset_illegal", illegal, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back vectors: one accept per cycle with out_ready held high
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].a_sel, vecs[i].b_sel, vecs[i].op, vecs[i].rs1, vecs[i].rs2,
                    vecs[i].pcv, vecs[i].immv, vecs[i].rd);
      #1 checkOutput($sformatf("vec%0d_in_ready", i), in_ready, 1);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_valid", i), out_valid, 1);
      checkOutput($sformatf("vec%0d_out", i), alu_out, vecs[i].exp_out);
      checkOutput($sformatf("vec%0d_illegal", i), illegal, vecs[i].exp_ill);
      checkOutput($sformatf("vec%0d_rd", i), out_rd_addr, vecs[i].rd);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("drain_valid", out_valid, 0);

    // Backpressure: result held for five cycles while a new op waits
    @(negedge clk);
    applyStimulus(2'd0, 2'd0, ADD, 32'd1, 32'd2, 32'h0, 32'h0, 5'd20);
    out_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("bp_first_valid", out_valid, 1);
    checkOutput("bp_first_out", alu_out, 3);
    @(negedge clk);
    applyStimulus(2'd0, 2'd0, ADD, 32'd10, 32'd20, 32'h0, 32'h0, 5'd21);
    for (int k = 0; k < 5; k++) begin
      #1 checkOutput($sformatf("bp_in_ready_%0d", k), in_ready, 0);
      @(posedge clk); #1;
      checkOutput($sformatf("bp_hold_out_%0d", k), alu_out, 3);
      checkOutput($sformatf("bp_hold_rd_%0d", k), out_rd_addr, 20);
      checkOutput($sformatf("bp_hold_valid_%0d", k), out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 checkOutput("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    checkOutput("bp_second_out", alu_out, 30);
    checkOutput("bp_second_rd", out_rd_addr, 21);
    checkOutput("bp_second_valid", out_valid, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("bp_drained", out_valid, 0);

    // Flush kills a held result and blocks a simultaneous new op
    @(negedge clk);
    applyStimulus(2'd0, 2'd0, ADD, 32'd4, 32'd4, 32'h0, 32'h0, 5'd3);
    out_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("fl_pre_valid", out_valid, 1);
    @(negedge clk);
    applyStimulus(2'd0, 2'd0, ADD, 32'd6, 32'd6, 32'h0, 32'h0, 5'd4);
    flush = 1'b1;
    #1 checkOutput("fl_in_ready", in_ready, 0);
    @(posedge clk); #1;
    checkOutput("fl_valid", out_valid, 0);
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1 checkOutput("fl_ready_after", in_ready, 1);
    @(posedge clk); #1;
    checkOutput("fl_no_accept", out_valid, 0);

    // Asynchronous reset clears a pending result without waiting for an edge
    singleOp("pre_rst", ADD, 32'd100, 32'd1, 32'd101, 1'b0);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid", out_valid, 0);
    checkOutput("arst_out", alu_out, 0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;

`ifdef EXECUTE_MULDIV_EN
    runM("mul",    MUL,    32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE);
    runM("mulhu",  MULHU,  32'hFFFFFFFF, 32'd2,        32'h00000001);
    runM("mulh",   MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    runM("mulhsu", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    runM("div0",   DIV,    32'd7,        32'd0,        32'hFFFFFFFF);
    runM("remu0",  REMU,   32'd7,        32'd0,        32'd7);
    runM("removf", REM,    32'h80000000, 32'hFFFFFFFF, 32'h0);
    runM("divovf", DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    runM("divneg", DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    runM("remneg", REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    runM("divu",   DIVU,   32'd100,      32'd7,        32'd14);

    // Flush in BUSY cycle 10 abandons the multiply
    @(negedge clk);
    applyStimulus(2'd0, 2'd0, MUL, 32'd3, 32'd5, 32'h0, 32'h0, 5'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    checkOutput("bflush_valid", out_valid, 0);
    @(negedge clk);
    flush = 1'b0;
    #1 checkOutput("bflush_ready", in_ready, 1);
    vcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) vcount++;
    end
    checkOutput("bflush_no_result", vcount, 0);
    singleOp("post_bflush", ADD, 32'd20, 32'd22, 32'd42, 1'b0);
`else
    singleOp("mul_off", MUL, 32'd3, 32'd5, 32'd0, 1'b1);
    singleOp("div_off", DIV, 32'd8, 32'd2, 32'd0, 1'b1);
`endif

    singleOp("post_op25", 5'd25, 32'd9, 32'd9, 32'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
